// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, word width and sign-restore stage payload.
package alu_pkg;
   localparam int WORD_W = 16;
   localparam logic ALU_OP_MUL = 1'b0;
   localparam logic ALU_OP_DIV = 1'b1;
   typedef struct packed {
      logic              op;
      logic              neg_a;
      logic              neg_b;
      logic              dz;
      logic              carry;
      logic [WORD_W-1:0] lo;
      logic [WORD_W-1:0] hi;
   } stage_t;
endpackage

// File: rtl/sign_restore_if.sv
// sign_restore_if: core-result input and signed-result output handshakes.
// out_ovf exists only when SIGN_RESTORE_OVF_EN is defined.
interface sign_restore_if #(parameter int W = alu_pkg::WORD_W);
   logic         in_valid;
   logic         in_ready;
   logic         in_op;
   logic         in_neg_a;
   logic         in_neg_b;
   logic         in_dz;
   logic [W-1:0] in_lo;
   logic [W-1:0] in_hi;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_lo;
   logic [W-1:0] out_hi;
`ifdef SIGN_RESTORE_OVF_EN
   logic         out_ovf;
   modport slave (input in_valid, in_op, in_neg_a, in_neg_b, in_dz, in_lo, in_hi, out_ready,
                  output in_ready, out_valid, out_lo, out_hi, out_ovf);
   modport master (output in_valid, in_op, in_neg_a, in_neg_b, in_dz, in_lo, in_hi, out_ready,
                   input in_ready, out_valid, out_lo, out_hi, out_ovf);
`else
   modport slave (input in_valid, in_op, in_neg_a, in_neg_b, in_dz, in_lo, in_hi, out_ready,
                  output in_ready, out_valid, out_lo, out_hi);
   modport master (output in_valid, in_op, in_neg_a, in_neg_b, in_dz, in_lo, in_hi, out_ready,
                   input in_ready, out_valid, out_lo, out_hi);
`endif
endinterface

// File: rtl/cond_neg.sv
// cond_neg: conditional two's-complement negate (~a + cin) with zero-detect carry-out.
module cond_neg #(parameter int W = 16) (
   input  logic         neg,
   input  logic         cin,
   input  logic [W-1:0] a,
   output logic [W-1:0] y,
   output logic         cout
);
   always_comb begin
      y    = neg ? ~a + W'(cin) : a;
      cout = neg & cin & (a == '0);
   end
endmodule

// File: rtl/sign_restore.sv
// sign_restore: two-stage pipeline re-applying operand signs to MUL/DIV magnitudes.
// Optional overflow flag output enabled by SIGN_RESTORE_OVF_EN.
module sign_restore import alu_pkg::*; #(parameter int W = WORD_W) (
   input logic           clk,
   input logic           rst,
   sign_restore_if.slave bus
);
   logic         s1_valid, s2_valid, s1_advance, neg_r, c1, s2_neg, s2_cin, unused_hi_c;
   logic [W-1:0] lo_neg, lo1, hi2;
   stage_t       s1;
   assign s1_advance    = !s2_valid | bus.out_ready;
   assign bus.in_ready  = !s1_valid | s1_advance;
   assign bus.out_valid = s2_valid;
   assign neg_r         = bus.in_neg_a ^ bus.in_neg_b;
   cond_neg #(.W(W)) u_lo (.neg(neg_r), .cin(1'b1), .a(bus.in_lo), .y(lo_neg), .cout(c1));
   assign lo1 = (bus.in_op == ALU_OP_DIV && bus.in_dz) ? '1 : lo_neg;
   // MUL finishes the 2W-bit negate with the low-word carry; a remainder takes the dividend sign
   assign s2_neg = (s1.op == ALU_OP_DIV) ? s1.neg_a : s1.neg_a ^ s1.neg_b;
   assign s2_cin = (s1.op == ALU_OP_DIV) | s1.carry;
   cond_neg #(.W(W)) u_hi (.neg(s2_neg), .cin(s2_cin), .a(s1.hi), .y(hi2), .cout(unused_hi_c));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid)
            s1 <= '{op: bus.in_op, neg_a: bus.in_neg_a, neg_b: bus.in_neg_b, dz: bus.in_dz,
                    carry: c1, lo: lo1, hi: bus.in_hi};
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         bus.out_lo <= '0;
         bus.out_hi <= '0;
      end else if (s1_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_lo <= s1.lo;
            bus.out_hi <= hi2;
         end
      end
   end
`ifdef SIGN_RESTORE_OVF_EN
   logic ovf2;
   // positive quotient of magnitude 2^(W-1) cannot be represented; lo still wraps to it
   assign ovf2 = (s1.op == ALU_OP_DIV) & !s1.dz & !(s1.neg_a ^ s1.neg_b) &
                 (s1.lo == {1'b1, {(W-1){1'b0}}});
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bus.out_ovf <= 1'b0;
      else if (s1_advance && s1_valid)
         bus.out_ovf <= ovf2;
   end
`endif
endmodule
